wishbone_register_bank: RTL and testbench

Parametrised Wishbone B3 classic slave holding NUM_REGS registers of DATA_WIDTH bits, each with per-bit read-only, live and sticky (write-1-to-clear) behaviour plus byte-lane writes. It is the next-generation replacement for the single-register peripheral slave: one bank sits behind the interconnect per peripheral and exposes all control/status words. It decodes a word address, flags out-of-range accesses with err, and emits per-register write strobes to the peripheral core.

---
 rtl/wishbone_register_bank.sv | 146 ++++++++++++++
 tb/tb_wishbone_register_bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_register_bank.sv
// Wishbone B3 classic slave exposing NUM_REGS control/status words.
// Each bit is read-only, sticky (W1C), live, or normal; writes are byte-laned.
module wishbone_register_bank #(
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 32,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] INITIAL_VALUES = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] READ_ONLY_BITS = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] LIVE_BITS      = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] STICKY_BITS    = '0
) (
    input  logic                           in_clock,
    input  logic                           in_reset_n,
    input  logic                           in_wb_cyc,
    input  logic                           in_wb_stb,
    input  logic                           in_wb_we,
    input  logic [ADDR_WIDTH-1:0]          in_wb_adr,
    input  logic [DATA_WIDTH/8-1:0]        in_wb_sel,
    input  logic [DATA_WIDTH-1:0]          in_wb_dat,
    output logic                           out_wb_ack,
    output logic                           out_wb_err,
    output logic [DATA_WIDTH-1:0]          out_wb_dat,
    output logic [NUM_REGS*DATA_WIDTH-1:0] out_contents,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] in_live_value,
    output logic [NUM_REGS-1:0]            out_write_strobe
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int FW = NUM_REGS * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, ACK, ERR, DONE} state_e;

    state_e                state_q, state_d;
    logic [FW-1:0]         contents_q, contents_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic [NUM_REGS-1:0]   strobe_q, strobe_d;

    logic                  req;
    logic                  in_range;
    logic [31:0]           adr_ext;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [NUM_REGS-1:0]   wr_en;

    assign adr_ext  = 32'(in_wb_adr);
    assign req      = in_wb_cyc & in_wb_stb & (state_q == IDLE);
    assign in_range = adr_ext < 32'(NUM_REGS);

    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < NB; b++) begin
            lane_mask[b*8 +: 8] = {8{in_wb_sel[b]}};
        end
    end

    always_comb begin
        wr_en = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            wr_en[k] = req & in_range & in_wb_we & (adr_ext == k);
        end
    end

    // Live bits lose to read-only and sticky classes on the read path.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (adr_ext == k) begin
                for (int b = 0; b < DATA_WIDTH; b++) begin
                    if (LIVE_BITS[k*DATA_WIDTH+b] &&
                        !READ_ONLY_BITS[k*DATA_WIDTH+b] &&
                        !STICKY_BITS[k*DATA_WIDTH+b]) begin
                        rd_word[b] = in_live_value[k*DATA_WIDTH+b];
                    end else begin
                        rd_word[b] = contents_q[k*DATA_WIDTH+b];
                    end
                end
            end
        end
    end

    // Sticky set is OR-ed in after the W1C clear so a same-cycle set wins.
    always_comb begin
        contents_d = contents_q;
        for (int k = 0; k < NUM_REGS; k++) begin
            for (int b = 0; b < DATA_WIDTH; b++) begin
                if (READ_ONLY_BITS[k*DATA_WIDTH+b]) begin
                    contents_d[k*DATA_WIDTH+b] = INITIAL_VALUES[k*DATA_WIDTH+b];
                end else if (STICKY_BITS[k*DATA_WIDTH+b]) begin
                    contents_d[k*DATA_WIDTH+b] =
                        in_live_value[k*DATA_WIDTH+b] |
                        (contents_q[k*DATA_WIDTH+b] &
                         ~(wr_en[k] & lane_mask[b] & in_wb_dat[b]));
                end else if (wr_en[k] && lane_mask[b]) begin
                    contents_d[k*DATA_WIDTH+b] = in_wb_dat[b];
                end
            end
        end
    end

    assign dat_d    = (req && in_range && !in_wb_we) ? rd_word : '0;
    assign strobe_d = wr_en;

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (in_wb_cyc && in_wb_stb) begin
                    state_d = in_range ? ACK : ERR;
                end
            end
            ACK:     state_d = DONE;
            ERR:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_wb_ack = (state_q == ACK);
        out_wb_err = (state_q == ERR);
        out_wb_dat = (state_q == ACK) ? dat_q : '0;
    end

    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            contents_q <= INITIAL_VALUES;
            dat_q      <= '0;
            strobe_q   <= '0;
        end else begin
            contents_q <= contents_d;
            dat_q      <= dat_d;
            strobe_q   <= strobe_d;
        end
    end

    assign out_contents     = contents_q;
    assign out_write_strobe = strobe_q;

endmodule

// File: tb/tb_wishbone_register_bank.sv
// Randomized bench for wishbone_register_bank against a word-level model
// of the bit classes (read-only, sticky W1C, live, normal).
module tb_wishbone_register_bank;
    localparam int NR = 4;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam logic [127:0] INIT = {32'h0, 32'h0, 32'hA5A5_0000, 32'h5A00_0000};
    localparam logic [127:0] RO   = {32'h0, 32'h0, 32'h0, 32'hFF00_0000};
    localparam logic [127:0] LV   = {32'h0000_00FF, 32'h0, 32'h0, 32'h0};
    localparam logic [127:0] ST   = {32'h0, 32'h0, 32'h0000_0001, 32'h0};

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cyc, stb, we;
    logic [AW-1:0] adr;
    logic [3:0]    sel;
    logic [DW-1:0] wdat;
    logic          ack, err;
    logic [DW-1:0] rdat;
    logic [127:0]  contents;
    logic [127:0]  live;
    logic [NR-1:0] strobe;

    logic [31:0]   model [NR];
    int            checks = 0;
    int            fails = 0;

    always #5 clk = ~clk;

    wishbone_register_bank #(
        .NUM_REGS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .INITIAL_VALUES(INIT), .READ_ONLY_BITS(RO),
        .LIVE_BITS(LV), .STICKY_BITS(ST)
    ) dut (
        .in_clock(clk), .in_reset_n(rst_n),
        .in_wb_cyc(cyc), .in_wb_stb(stb), .in_wb_we(we),
        .in_wb_adr(adr), .in_wb_sel(sel), .in_wb_dat(wdat),
        .out_wb_ack(ack), .out_wb_err(err), .out_wb_dat(rdat),
        .out_contents(contents), .in_live_value(live),
        .out_write_strobe(strobe)
    );

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [127:0] v, input int k);
        return v[k*32 +: 32];
    endfunction

    function automatic logic [127:0] flat();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < NR; r++) model[r] = word(INIT, r);
    endfunction

    function automatic logic [31:0] model_read(input int k);
        logic [31:0] lm;
        lm = word(LV, k) & ~word(RO, k) & ~word(ST, k);
        return (model[k] & ~lm) | (word(live, k) & lm);
    endfunction

    // One rising edge: sticky bits absorb live, plus an optional write.
    task automatic clk_edge(input bit wr, input int k, input logic [3:0] s,
                            input logic [31:0] d);
        logic [31:0] ro, st, nm, wm;
        @(posedge clk);
        for (int r = 0; r < NR; r++) begin
            ro = word(RO, r);
            st = word(ST, r) & ~ro;
            nm = ~ro & ~st;
            wm = '0;
            if (wr && r == k) wm = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
            model[r] = (word(INIT, r) & ro)
                     | (((model[r] & ~wm) | (d & wm)) & nm)
                     | (((model[r] & ~(wm & d)) | word(live, r)) & st);
        end
    endtask

    task automatic idle(input logic [127:0] lv);
        @(negedge clk);
        live = lv;
        clk_edge(1'b0, 0, 4'h0, 32'h0);
    endtask

    task automatic xfer(input bit w, input int a, input logic [3:0] s,
                        input logic [31:0] d, input logic [127:0] lv,
                        input logic [127:0] lv2, output logic [31:0] rd);
        bit          ok;
        logic [31:0] exp_rd;
        logic [3:0]  exp_st;
        ok = (a < NR);
        @(negedge clk);
        live = lv;
        cyc = 1'b1; stb = 1'b1; we = w;
        adr = a[AW-1:0]; sel = s; wdat = d;
        exp_rd = (ok && !w) ? model_read(a) : 32'h0;
        exp_st = (ok && w) ? (4'b0001 << a) : 4'b0000;
        clk_edge(ok && w, a, s, d);
        #1;
        check("ack", ack, ok);
        check("err", err, !ok);
        check("ack_dat", rdat, exp_rd);
        check("strobe", strobe, exp_st);
        check("contents_ack", contents, flat());
        rd = rdat;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        live = lv2;
        clk_edge(1'b0, 0, 4'h0, 32'h0);
        #1;
        check("done_ackerr", {ack, err}, 2'b00);
        check("done_dat", rdat, 32'h0);
        check("done_strobe", strobe, 4'h0);
        clk_edge(1'b0, 0, 4'h0, 32'h0);
        #1;
        check("contents_idle", contents, flat());
    endtask

    logic [31:0]  r;
    logic [127:0] l1, l2;

    initial begin
        cyc = 0; stb = 0; we = 0; adr = '0; sel = '0; wdat = '0; live = '0;
        #1 rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", ack, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_dat", rdat, 32'h0);
        check("rst_strobe", strobe, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_contents", contents, INIT);

        xfer(0, 1, 4'hF, 0, '0, '0, r);
        check("init_reg1", r, 32'hA5A5_0000);

        xfer(1, 2, 4'b0101, 32'h1234_5678, '0, '0, r);
        xfer(0, 2, 4'hF, 0, '0, '0, r);
        check("lanes_reg2", r, 32'h0034_0078);

        xfer(1, 0, 4'hF, 32'hFFFF_FFFF, '0, '0, r);
        xfer(0, 0, 4'hF, 0, '0, '0, r);
        check("ro_reg0", r, 32'h5AFF_FFFF);

        l1 = '0; l1[96 +: 32] = 32'h3C;
        xfer(1, 3, 4'hF, 32'h11, l1, l1, r);
        xfer(0, 3, 4'hF, 0, l1, l1, r);
        check("live_reg3", r, 32'h0000_003C);
        check("live_store", contents[96 +: 8], 8'h11);

        l1 = '0; l1[32] = 1'b1;
        idle(l1);
        idle('0);
        xfer(0, 1, 4'hF, 0, '0, '0, r);
        check("sticky_set", r, 32'hA5A5_0001);
        xfer(1, 1, 4'hF, 32'hA5A5_0000, '0, '0, r);
        xfer(0, 1, 4'hF, 0, '0, '0, r);
        check("sticky_w0", r, 32'hA5A5_0001);
        xfer(1, 1, 4'hF, 32'hA5A5_0001, '0, '0, r);
        xfer(0, 1, 4'hF, 0, '0, '0, r);
        check("sticky_w1c", r, 32'hA5A5_0000);
        xfer(1, 1, 4'hF, 32'hA5A5_0001, l1, '0, r);
        xfer(0, 1, 4'hF, 0, '0, '0, r);
        check("sticky_setwins", r, 32'hA5A5_0001);

        xfer(1, 2, 4'h0, 32'hFFFF_FFFF, '0, '0, r);
        xfer(1, 5, 4'hF, 32'h0000_DEAD, '0, '0, r);

        for (int i = 0; i < 200; i++) begin
            l1 = {$urandom(), $urandom(), $urandom(), $urandom()};
            l2 = {$urandom(), $urandom(), $urandom(), $urandom()};
            l1[32] = ($urandom_range(0, 3) == 0);
            l2[32] = ($urandom_range(0, 3) == 0);
            xfer(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 4'($urandom()), $urandom(), l1, l2, r);
        end

        @(negedge clk);
        live = '0;
        cyc = 1; stb = 1; we = 1; adr = 3'd2; sel = 4'hF; wdat = 32'hCAFE_F00D;
        clk_edge(1'b1, 2, 4'hF, 32'hCAFE_F00D);
        #1;
        check("mid_ack_pre", ack, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_ack_drop", ack, 1'b0);
        check("mid_strobe", strobe, 4'h0);
        check("mid_contents", contents, flat());
        @(negedge clk);
        cyc = 0; stb = 0; we = 0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(0, 2, 4'hF, 0, '0, '0, r);
        check("post_rst_reg2", r, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
